// File: rtl/lc_transition_ctrl.sv
// Lifecycle-transition controller: checks an unlock token against the lifecycle ROM
// and advances the lifecycle index forward only, with a sticky lockout after repeated failures.
module lc_transition_ctrl #(
   parameter int WIDTH    = 256,
   parameter int LENGTH   = 6,
   parameter int MAX_FAIL = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [$clog2(LENGTH)-1:0]  req_target,
   input  logic [WIDTH-1:0]           req_token,
   output logic                       resp_valid,
   output logic [1:0]                 resp_err,
   output logic [$clog2(LENGTH)-1:0]  lc_state,
   output logic                       locked,
   output logic                       mem_rd_en,
   output logic [$clog2(LENGTH)-1:0]  mem_addr,
   input  logic [WIDTH-1:0]           mem_rdData,
   input  logic                       mem_valid
);

   localparam int AW = $clog2(LENGTH);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam logic [AW:0]   LEN_C = LENGTH[AW:0];
   localparam logic [FW-1:0] MAX_C = MAX_FAIL[FW-1:0];

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0] ERR_MISMATCH = 2'd2;
   localparam logic [1:0] ERR_LOCKED   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT} state_t;

   state_t          state;
   logic [AW-1:0]   tgt_q;
   logic [WIDTH-1:0] tok_q;
   logic [FW-1:0]   fail_cnt;
   logic [FW-1:0]   fail_nxt;
   logic [1:0]      wd_cnt;
   logic            illegal;
   logic            tok_match;

   function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
      return (v >= MAX_C) ? MAX_C : v + 1'b1;
   endfunction

   assign fail_nxt  = sat_inc(fail_cnt);
   assign illegal   = (req_target <= lc_state) || ({1'b0, req_target} >= LEN_C);
   assign tok_match = (mem_rdData == tok_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= ERR_OK;
         lc_state   <= '0;
         locked     <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         tgt_q      <= '0;
         tok_q      <= '0;
         fail_cnt   <= '0;
         wd_cnt     <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (locked) begin
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_LOCKED;
                  end else if (illegal) begin
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_ILLEGAL;
                  end else begin
                     // read strobe is registered here so it is high for exactly the RD cycle
                     state     <= S_RD;
                     req_ready <= 1'b0;
                     tgt_q     <= req_target;
                     tok_q     <= req_token;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= req_target;
                  end
               end
            end
            S_RD: begin
               state     <= S_WAIT;
               mem_rd_en <= 1'b0;
               mem_addr  <= '0;
               wd_cnt    <= '0;
            end
            S_WAIT: begin
               if (mem_valid || wd_cnt == 2'd3) begin
                  state      <= S_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b1;
                  tgt_q      <= '0;
                  tok_q      <= '0;
                  wd_cnt     <= '0;
                  if (mem_valid && tok_match) begin
                     lc_state <= tgt_q;
                     fail_cnt <= '0;
                     resp_err <= ERR_OK;
                  end else begin
                     // a silent memory counts as a failed attempt
                     fail_cnt <= fail_nxt;
                     resp_err <= ERR_MISMATCH;
                     if (fail_nxt == MAX_C)
                        locked <= 1'b1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 2'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
